// File: rtl/pci_arbiter_rr_if.sv
// Shared-bus view seen by the round-robin PCI arbiter: bus phase tracking inputs,
// per-agent REQ#/GNT# pairs and arbiter status. The master modport is the arbiter side.
interface pci_arbiter_rr_if #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
);
  logic             PCI_FRAMEn;
  logic             PCI_IRDYn;
  logic [N_REQ-1:0] PCI_REQn;
  logic [N_REQ-1:0] PCI_GNTn;
  logic [IDX_W-1:0] ARB_OWNER;
  logic             ARB_TIMEOUT;

  modport master (
    input  PCI_FRAMEn,
    input  PCI_IRDYn,
    input  PCI_REQn,
    output PCI_GNTn,
    output ARB_OWNER,
    output ARB_TIMEOUT
  );

  modport slave (
    output PCI_FRAMEn,
    output PCI_IRDYn,
    output PCI_REQn,
    input  PCI_GNTn,
    input  ARB_OWNER,
    input  ARB_TIMEOUT
  );
endinterface

// File: rtl/pci_arbiter_rr.sv
// Round-robin PCI arbiter: registered one-hot-low grants, forced turnaround, hidden
// arbitration and idle-bus grant timeout. Bus parking is enabled by PCI_ARB_PARK_EN.
module pci_arbiter_rr #(
  parameter int N_REQ       = 4,
  parameter int GNT_TIMEOUT = 16,
  parameter int PARK_AGENT  = 0,
  parameter int IDX_W       = $clog2(N_REQ)
) (
  input  logic                    PCI_CLK,
  input  logic                    PCI_RSTn,
  pci_arbiter_rr_if.master        bus,
  output logic [1:0]              o_state
);

  // Handshake: an agent holds REQ# low while it wants the bus; a low GNT# means it may
  // start FRAME# once the bus is idle. GNT# can be withdrawn at any time; an agent
  // already in a transfer finishes it under its own latency timer.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_XFER  = 2'd2,
    S_TURN  = 2'd3
  } state_t;

  localparam int               TMR_W    = $clog2(GNT_TIMEOUT) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GNT_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
`ifdef PCI_ARB_PARK_EN
  localparam logic [IDX_W-1:0] PARK_IDX = IDX_W'(PARK_AGENT);
`endif

  if (N_REQ < 2 || N_REQ > 16 || GNT_TIMEOUT < 1 || PARK_AGENT < 0 || PARK_AGENT >= N_REQ)
  begin : g_param_check
    $error("pci_arbiter_rr: parameter out of range");
  end

  state_t             r_state;
  logic [N_REQ-1:0]   r_gnt_n;
  logic [IDX_W-1:0]   r_owner;
  logic [IDX_W-1:0]   r_ptr;
  logic [TMR_W-1:0]   r_timer;
  logic               r_timeout;
  logic               r_bus_idle_q;

  logic               w_bus_idle;
  logic               w_start;
  logic               w_any_req;
  logic               w_owner_req;
  logic               w_other_req;
  logic [IDX_W-1:0]   w_winner;
  logic [IDX_W-1:0]   w_scan;
  logic               w_found;

  function automatic logic [N_REQ-1:0] gnt_of(input logic [IDX_W-1:0] idx);
    return ~({{(N_REQ-1){1'b0}}, 1'b1} << idx);
  endfunction

  assign w_bus_idle  = bus.PCI_FRAMEn & bus.PCI_IRDYn;
  assign w_start     = ~bus.PCI_FRAMEn & r_bus_idle_q;
  assign w_any_req   = ~&bus.PCI_REQn;
  assign w_owner_req = ~bus.PCI_REQn[r_owner];
  assign w_other_req = ~&(bus.PCI_REQn | ~gnt_of(r_owner));

  // First requester after the pointer, wrapping; the pointer holds the last agent served.
  always_comb begin
    w_winner = r_ptr;
    w_found  = 1'b0;
    w_scan   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_scan = IDX_W'((int'(r_ptr) + k) % N_REQ);
      if (!w_found && !bus.PCI_REQn[w_scan]) begin
        w_winner = w_scan;
        w_found  = 1'b1;
      end
    end
  end

  always_ff @(posedge PCI_CLK or negedge PCI_RSTn) begin
    if (!PCI_RSTn) begin
      r_state      <= S_IDLE;
      r_gnt_n      <= '1;
      r_owner      <= '0;
      r_ptr        <= LAST_IDX;
      r_timer      <= '0;
      r_timeout    <= 1'b0;
      r_bus_idle_q <= 1'b1;
    end else begin
      r_bus_idle_q <= w_bus_idle;
      r_timeout    <= 1'b0;
      case (r_state)
        S_IDLE: begin
`ifdef PCI_ARB_PARK_EN
          if (w_start && !r_gnt_n[PARK_IDX]) begin
            r_owner <= PARK_IDX;
            r_ptr   <= PARK_IDX;
            r_state <= S_XFER;
          end else if (w_any_req) begin
            // A live park grant must pass through TURN before another agent gets the bus.
            if (w_winner == PARK_IDX || r_gnt_n[PARK_IDX]) begin
              r_owner <= w_winner;
              r_gnt_n <= gnt_of(w_winner);
              r_timer <= '0;
              r_state <= S_GRANT;
            end else begin
              r_gnt_n <= '1;
              r_state <= S_TURN;
            end
          end else begin
            r_gnt_n <= gnt_of(PARK_IDX);
            r_owner <= PARK_IDX;
          end
`else
          if (w_any_req) begin
            r_owner <= w_winner;
            r_gnt_n <= gnt_of(w_winner);
            r_timer <= '0;
            r_state <= S_GRANT;
          end
`endif
        end

        S_GRANT: begin
          if (w_start) begin
            r_ptr   <= r_owner;
            r_state <= S_XFER;
          end else if (!w_owner_req) begin
            r_gnt_n <= '1;
            r_state <= S_TURN;
          end else if (w_bus_idle) begin
            // Only idle clocks count; a hidden grant waits out the previous transfer.
            if (r_timer == TMR_LAST) begin
              r_timeout <= 1'b1;
              r_ptr     <= r_owner;
              r_gnt_n   <= '1;
              r_state   <= S_TURN;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
        end

        S_XFER: begin
          if (w_other_req) begin
            r_gnt_n <= '1;
            r_state <= S_TURN;
          end else if (w_bus_idle) begin
            if (w_owner_req) begin
              r_timer <= '0;
              r_state <= S_GRANT;
            end else begin
              r_gnt_n <= '1;
              r_state <= S_TURN;
            end
          end
        end

        S_TURN: begin
          if (w_any_req) begin
            r_owner <= w_winner;
            r_gnt_n <= gnt_of(w_winner);
            r_timer <= '0;
            r_state <= S_GRANT;
          end else begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_gnt_n <= '1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.PCI_GNTn    = r_gnt_n;
  assign bus.ARB_OWNER   = r_owner;
  assign bus.ARB_TIMEOUT = r_timeout;
  assign o_state         = r_state;

endmodule

// File: tb/tb_pci_arbiter_rr.sv
// Self-checking bench for pci_arbiter_rr (N_REQ=4, GNT_TIMEOUT=16); the park scenario
// runs instead of the main sequence when PCI_ARB_PARK_EN is defined.
module tb_pci_arbiter_rr;

`ifdef PCI_ARB_PARK_EN
  localparam int PARK = 3;
`else
  localparam int PARK = 0;
`endif
  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  pci_arbiter_rr_if #(.N_REQ(4)) bus ();

  pci_arbiter_rr #(
    .N_REQ(4), .GNT_TIMEOUT(TMO), .PARK_AGENT(PARK)
  ) dut (
    .PCI_CLK(clk), .PCI_RSTn(rst_n), .bus(bus), .o_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Reference rules: grant vector is one low bit; winner is the first requester after ptr.
  function automatic logic [3:0] gnt_exp(input int a);
    return 4'b1111 ^ (4'b0001 << a);
  endfunction

  function automatic int rr_next(input int ptr, input logic [3:0] req_n);
    int act;
    act = int'(~req_n) & 15;
    for (int off = 1; off <= 4; off++)
      if (((act >> ((ptr + off) % 4)) & 1) == 1) return (ptr + off) % 4;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_gnt(input string tag, input logic [3:0] exp);
    n_checks++;
    assert (bus.PCI_GNTn === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed GNTn=%b expected %b", tag, bus.PCI_GNTn, exp);
    end
  endtask

  task automatic chk_own(input string tag, input int exp);
    n_checks++;
    assert (bus.ARB_OWNER === 2'(exp)) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed owner=%0d expected %0d", tag, bus.ARB_OWNER, exp);
    end
  endtask

  task automatic chk_to(input string tag, input logic exp);
    n_checks++;
    assert (bus.ARB_TIMEOUT === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed timeout=%b expected %b", tag, bus.ARB_TIMEOUT, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs == exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Never more than one grant low, checked on every falling edge out of reset.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_checks++;
      assert ($countones(~bus.PCI_GNTn) <= 1) n_pass++;
      else begin
        n_fail++;
        $error("FAIL onehot_gnt: observed GNTn=%b expected at most one low", bus.PCI_GNTn);
      end
    end
  end

  initial begin
    int         m_ptr;
    int         w;
    int         cnt;
    int         busy;
    int         pulses;
    int         n_ph;
    logic [3:0] act;
    logic [3:0] req_addr;
    logic [3:0] req_data;
    logic [3:0] req_next;
    int         order [5];

    order = '{0, 1, 2, 3, 0};
    rst_n          = 1'b0;
    bus.PCI_FRAMEn = 1'b1;
    bus.PCI_IRDYn  = 1'b1;
    bus.PCI_REQn   = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    chk_gnt("reset_gnt", 4'hF);
    chk_own("reset_owner", 0);
    chk_to("reset_timeout", 1'b0);
    rst_n = 1'b1;
    m_ptr = 3;

`ifdef PCI_ARB_PARK_EN
    step();
    step();
    chk_gnt("park_idle", 4'b0111);
    chk_own("park_owner", 3);
    bus.PCI_REQn = 4'b1110;
    step();
    chk_gnt("park_turn", 4'hF);
    step();
    chk_gnt("park_grant0", 4'b1110);
    chk_own("park_owner0", 0);
    bus.PCI_REQn = 4'hF;
    repeat (3) step();
    chk_gnt("park_return", 4'b0111);
    bus.PCI_FRAMEn = 1'b0;
    step();
    chk_gnt("park_start_xfer", 4'b0111);
    chk_own("park_start_owner", 3);
    bus.PCI_FRAMEn = 1'b1;
    bus.PCI_IRDYn  = 1'b0;
    step();
    bus.PCI_IRDYn  = 1'b1;
    repeat (3) step();
    chk_gnt("park_after_xfer", 4'b0111);
`else
    step();
    chk_gnt("idle_no_req", 4'hF);

    // First grant latency and asynchronous reset while granted
    bus.PCI_REQn = 4'b1110;
    step();
    chk_gnt("first_gnt", 4'b1110);
    chk_own("first_owner", 0);
    #2 rst_n = 1'b0;
    #1;
    chk_gnt("async_rst_gnt", 4'hF);
    chk_own("async_rst_owner", 0);
    bus.PCI_REQn = 4'hF;
    step();
    rst_n = 1'b1;
    m_ptr = 3;

    // All four request; single-data-phase transfer per grant
    bus.PCI_REQn = 4'h0;
    step();
    for (int g = 0; g < 5; g++) begin
      chk_gnt($sformatf("rr_gnt%0d", g), gnt_exp(order[g]));
      chk_own($sformatf("rr_owner%0d", g), order[g]);
      bus.PCI_FRAMEn = 1'b0; bus.PCI_IRDYn = 1'b1;
      step();
      chk_gnt($sformatf("rr_xfer%0d", g), gnt_exp(order[g]));
      m_ptr = order[g];
      bus.PCI_FRAMEn = 1'b1; bus.PCI_IRDYn = 1'b0;
      step();
      chk_gnt($sformatf("rr_turn%0d", g), 4'hF);
      bus.PCI_IRDYn = 1'b1;
      step();
    end
    bus.PCI_REQn = 4'hF;
    repeat (2) step();
    chk_gnt("rr_release", 4'hF);

    // Random request patterns against the round-robin rule
    bus.PCI_REQn = ~4'($urandom_range(1, 15));
    step();
    for (int r = 0; r < 16; r++) begin
      w = rr_next(m_ptr, bus.PCI_REQn);
      chk_gnt($sformatf("rnd_gnt%0d", r), gnt_exp(w));
      chk_own($sformatf("rnd_owner%0d", r), w);
      req_addr = 4'($urandom_range(0, 15));
      act = 4'($urandom_range(0, 15)) | (4'b0001 << ((w + 1 + $urandom_range(0, 2)) % 4));
      req_data = ~act;
      req_next = ~4'($urandom_range(1, 15));
      bus.PCI_FRAMEn = 1'b0; bus.PCI_IRDYn = 1'b1; bus.PCI_REQn = req_addr;
      step();
      chk_gnt($sformatf("rnd_xfer%0d", r), gnt_exp(w));
      m_ptr = w;
      bus.PCI_FRAMEn = 1'b1; bus.PCI_IRDYn = 1'b0; bus.PCI_REQn = req_data;
      step();
      chk_gnt($sformatf("rnd_turn%0d", r), 4'hF);
      bus.PCI_IRDYn = 1'b1; bus.PCI_REQn = req_next;
      step();
    end
    w = rr_next(m_ptr, bus.PCI_REQn);
    chk_gnt("rnd_last_gnt", gnt_exp(w));
    bus.PCI_REQn = 4'hF;
    repeat (2) step();
    chk_gnt("rnd_release", 4'hF);

    // Agent 2 never starts: grant revoked after GNT_TIMEOUT idle clocks
    bus.PCI_REQn = 4'b1011;
    step();
    chk_gnt("tmo_gnt2", gnt_exp(2));
    bus.PCI_REQn = 4'b0011;
    cnt = 1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.ARB_TIMEOUT === 1'b1) pulses++;
      if (bus.PCI_GNTn !== gnt_exp(2)) break;
      cnt++;
    end
    chk_int("tmo_len", cnt, TMO);
    chk_to("tmo_pulse", 1'b1);
    chk_gnt("tmo_revoked", 4'hF);
    m_ptr = 2;
    step();
    chk_to("tmo_pulse_end", 1'b0);
    chk_int("tmo_pulse_count", pulses, 1);
    chk_gnt("tmo_next_gnt", gnt_exp(rr_next(m_ptr, bus.PCI_REQn)));
    bus.PCI_REQn = 4'hF;
    repeat (2) step();

    // Start on the clock the timer would expire: start wins
    bus.PCI_REQn = 4'b1011;
    step();
    chk_gnt("race_gnt2", gnt_exp(2));
    repeat (TMO - 1) step();
    chk_gnt("race_hold", gnt_exp(2));
    bus.PCI_FRAMEn = 1'b0;
    step();
    chk_gnt("race_start_wins", gnt_exp(2));
    chk_to("race_no_timeout", 1'b0);
    m_ptr = 2;
    bus.PCI_FRAMEn = 1'b1; bus.PCI_IRDYn = 1'b0;
    step();
    bus.PCI_IRDYn = 1'b1; bus.PCI_REQn = 4'hF;
    step();
    chk_gnt("race_release", 4'hF);
    step();

    // Agent 0 bursts, agent 1 requests: hidden grant, timer frozen while busy
    bus.PCI_REQn = 4'b1110;
    step();
    chk_gnt("hid_gnt0", 4'b1110);
    n_ph = $urandom_range(5, 10);
    bus.PCI_FRAMEn = 1'b0; bus.PCI_IRDYn = 1'b1;
    step();
    chk_gnt("hid_xfer0", 4'b1110);
    m_ptr = 0;
    bus.PCI_IRDYn = 1'b0; bus.PCI_REQn = 4'b1100;
    step();
    chk_gnt("hid_turn", 4'hF);
    step();
    chk_gnt("hid_gnt1_busy", 4'b1101);
    chk_own("hid_owner1", 1);
    cnt = 1;
    busy = 0;
    for (int k = 3; k <= n_ph; k++) begin
      bus.PCI_FRAMEn = (k == n_ph) ? 1'b1 : 1'b0;
      step();
      busy++;
      if (bus.PCI_GNTn === 4'b1101) cnt++;
    end
    bus.PCI_FRAMEn = 1'b1; bus.PCI_IRDYn = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (bus.PCI_GNTn !== 4'b1101) break;
      cnt++;
    end
    chk_int("hid_gnt1_len", cnt, busy + TMO);
    chk_to("hid_timeout", 1'b1);
    m_ptr = 1;
    step();
    chk_gnt("hid_next", gnt_exp(rr_next(m_ptr, bus.PCI_REQn)));
    bus.PCI_REQn = 4'hF;
    repeat (2) step();

    // Sole requester back-to-back: grant never drops
    bus.PCI_REQn = 4'b1101;
    step();
    chk_gnt("sole_gnt1", 4'b1101);
    cnt = 0;
    for (int t = 0; t < 3; t++) begin
      bus.PCI_FRAMEn = 1'b0; bus.PCI_IRDYn = 1'b1;
      step();
      if (bus.PCI_GNTn === 4'b1101) cnt++;
      bus.PCI_FRAMEn = 1'b1; bus.PCI_IRDYn = 1'b0;
      step();
      if (bus.PCI_GNTn === 4'b1101) cnt++;
      bus.PCI_IRDYn = 1'b1;
      step();
      if (bus.PCI_GNTn === 4'b1101) cnt++;
    end
    chk_int("sole_stable", cnt, 9);
    m_ptr = 1;
    bus.PCI_REQn = 4'b1010;
    step();
    chk_gnt("sole_release_turn", 4'hF);
    step();
    chk_gnt("sole_ptr_next", gnt_exp(rr_next(m_ptr, 4'b1010)));
    chk_own("sole_ptr_owner", 2);
    bus.PCI_REQn = 4'hF;
    repeat (2) step();
    chk_gnt("final_idle", 4'hF);
    chk_to("final_timeout", 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
